// File: rtl/sinh_cosh_h_if.sv
// Start/angle/result bundle for the hyperbolic CORDIC block.
// The master drives the request (st, z_in); the slave returns results and status.
interface sinh_cosh_h_if #(
    parameter int N = 16
);
    logic         st;
    logic [N-1:0] z_in;
    logic [N-1:0] cosh_out;
    logic [N-1:0] sinh_out;
    logic         busy;
    logic         done;

    modport master (
        output st,
        output z_in,
        input  cosh_out,
        input  sinh_out,
        input  busy,
        input  done
    );

    modport slave (
        input  st,
        input  z_in,
        output cosh_out,
        output sinh_out,
        output busy,
        output done
    );
endinterface

// File: rtl/sinh_cosh_h.sv
// Iterative hyperbolic CORDIC in rotation mode, Q2.14 fixed point.
// One micro-rotation per clock, 17 rotations (shift 4 and 13 repeated for
// convergence). x starts at 1/K_h, so x/y land directly on cosh/sinh.
module sinh_cosh_h #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sinh_cosh_h_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 1/K_h in Q2.14 (1.20750), compensates the CORDIC gain up front.
    localparam logic signed [N-1:0] X_INIT   = 16'sh4D48;
    localparam logic signed [N-1:0] Z_MAX    = 16'sh4000;
    localparam logic signed [N-1:0] Z_MIN    = -16'sh4000;
    localparam logic [4:0]          LAST_STP = 5'd16;

    state_t               state_q, state_d;
    logic signed [N-1:0]  x_q, x_d;
    logic signed [N-1:0]  y_q, y_d;
    logic signed [N-1:0]  z_q, z_d;
    logic [4:0]           step_q, step_d;
    logic signed [N-1:0]  cosh_q, cosh_d;
    logic signed [N-1:0]  sinh_q, sinh_d;
    logic                 done_q, done_d;

    logic [3:0]           shift_idx;
    logic signed [N-1:0]  atanh_val;
    logic signed [N-1:0]  x_sh;
    logic signed [N-1:0]  y_sh;
    logic signed [N-1:0]  z_in_s;
    logic signed [N-1:0]  z_sat;
    logic                 d_pos;

    // Map rotation step to shift index: 1,2,3,4,4,5..13,13,14,15.
    always_comb begin
        shift_idx = 4'd0;
        if (step_q <= 5'd3) begin
            shift_idx = 4'(step_q + 5'd1);
        end else if (step_q <= 5'd13) begin
            shift_idx = 4'(step_q);
        end else begin
            shift_idx = 4'(step_q - 5'd1);
        end
    end

    // atanh(2^-i) table in Q2.14.
    always_comb begin
        atanh_val = '0;
        case (shift_idx)
            4'd1:    atanh_val = 16'sh2327;
            4'd2:    atanh_val = 16'sh1058;
            4'd3:    atanh_val = 16'sh080A;
            4'd4:    atanh_val = 16'sh0401;
            4'd5:    atanh_val = 16'sh0200;
            4'd6:    atanh_val = 16'sh0100;
            4'd7:    atanh_val = 16'sh0080;
            4'd8:    atanh_val = 16'sh0040;
            4'd9:    atanh_val = 16'sh0020;
            4'd10:   atanh_val = 16'sh0010;
            4'd11:   atanh_val = 16'sh0008;
            4'd12:   atanh_val = 16'sh0004;
            4'd13:   atanh_val = 16'sh0002;
            4'd14:   atanh_val = 16'sh0001;
            default: atanh_val = 16'sh0000;
        endcase
    end

    assign x_sh   = x_q >>> shift_idx;
    assign y_sh   = y_q >>> shift_idx;
    assign d_pos  = ~z_q[N-1];
    assign z_in_s = bus.z_in;

    // Clamp the incoming angle into the convergent range [-1.0, +1.0].
    always_comb begin
        z_sat = z_in_s;
        if (z_in_s > Z_MAX) begin
            z_sat = Z_MAX;
        end else if (z_in_s < Z_MIN) begin
            z_sat = Z_MIN;
        end
    end

    // Next-state and datapath: load on start, rotate in RUN, publish in DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        step_d  = step_q;
        cosh_d  = cosh_q;
        sinh_d  = sinh_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.st) begin
                    state_d = RUN;
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = z_sat;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (d_pos) begin
                    x_d = x_q + y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atanh_val;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atanh_val;
                end
                step_d = step_q + 5'd1;
                if (step_q == LAST_STP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cosh_d  = x_q;
                sinh_d  = y_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            step_q  <= '0;
            cosh_q  <= '0;
            sinh_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            step_q  <= step_d;
            cosh_q  <= cosh_d;
            sinh_q  <= sinh_d;
            done_q  <= done_d;
        end
    end

    assign bus.cosh_out = cosh_q;
    assign bus.sinh_out = sinh_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sinh_cosh_h.sv
// Directed bench for sinh_cosh_h: reset, latency, angle table, ignored
// start while busy, mid-run reset and back-to-back operation.
module tb_sinh_cosh_h;
    localparam int TOL     = 8;
    localparam int TIMEOUT = 40;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sinh_cosh_h_if #(.N(16)) bus ();

    sinh_cosh_h #(.N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Issue a start and wait for done; lat = edges after start edge, -1 on timeout.
    task automatic run_op(input logic [15:0] z, output int lat,
                          output int c, output int s);
        lat = -1;
        @(negedge clk);
        bus.z_in = z;
        bus.st   = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        c = int'($signed(bus.cosh_out));
        s = int'($signed(bus.sinh_out));
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.st   = 1'b0;
        bus.z_in = 16'h0000;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.cosh_out !== 16'h0000 || bus.sinh_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b cosh=%h sinh=%h, required 0 0 0000 0000",
                     bus.busy, bus.done, bus.cosh_out, bus.sinh_out);
        end
        $display("reset: busy=%b done=%b cosh=%h sinh=%h",
                 bus.busy, bus.done, bus.cosh_out, bus.sinh_out);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // z=0 with explicit busy window and exact latency check.
    task automatic test_zero();
        int lat;
        int busy_bad;
        int c;
        int s;
        lat      = -1;
        busy_bad = 0;
        @(negedge clk);
        bus.z_in = 16'h0000;
        bus.st   = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
        if (bus.busy !== 1'b1) busy_bad++;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
        end
        c = int'($signed(bus.cosh_out));
        s = int'($signed(bus.sinh_out));
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL zero_latency: done after %0d edges, required 18", lat);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL zero_busy: busy low in %0d cycles of E0..E17, required 0", busy_bad);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy_end: busy=%b after E18, required 0", bus.busy);
        end
        checks++;
        if (absdiff(c, 16384) > TOL || absdiff(s, 0) > TOL) begin
            errors++;
            $display("FAIL zero_result: cosh=%0d sinh=%0d, required 16384 0 (+-8)", c, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width: done=%b at E19, required 0", bus.done);
        end
        $display("zero: z=0000 lat=%0d cosh=%0d sinh=%0d", lat, c, s);
    endtask

    task automatic test_angles();
        logic [15:0] zv [6];
        int          ec [6];
        int          es [6];
        int          lat;
        int          c;
        int          s;
        zv = '{16'h2000, 16'hE000, 16'h4000, 16'h6000, 16'hC000, 16'hA000};
        ec = '{18475, 18475, 25281, 25281, 25281, 25281};
        es = '{8538, -8538, 19254, 19254, -19254, -19254};
        for (int k = 0; k < 6; k++) begin
            run_op(zv[k], lat, c, s);
            checks++;
            if (lat != 18 || absdiff(c, ec[k]) > TOL || absdiff(s, es[k]) > TOL) begin
                errors++;
                $display("FAIL angle_%h: lat=%0d cosh=%0d sinh=%0d, required 18 %0d %0d (+-8)",
                         zv[k], lat, c, s, ec[k], es[k]);
            end
            $display("angle: z=%h lat=%0d cosh=%0d sinh=%0d", zv[k], lat, c, s);
        end
    endtask

    // A start pulse plus z_in change mid-run must not disturb the operation.
    task automatic test_ignore_st();
        int lat;
        int pulses;
        int c;
        int s;
        lat    = -1;
        pulses = 0;
        @(negedge clk);
        bus.z_in = 16'h2000;
        bus.st   = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            if (n == 5) begin
                bus.st   = 1'b1;
                bus.z_in = 16'hC000;
            end
            @(posedge clk);
            #1;
            if (n == 5) bus.st = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = n;
                c = int'($signed(bus.cosh_out));
                s = int'($signed(bus.sinh_out));
            end
            if (n >= 24) break;
        end
        checks++;
        if (lat != 18 || pulses != 1) begin
            errors++;
            $display("FAIL ignore_st_done: first done at %0d, pulses=%0d, required 18 and 1",
                     lat, pulses);
        end
        checks++;
        if (pulses == 0 || absdiff(c, 18475) > TOL || absdiff(s, 8538) > TOL) begin
            errors++;
            $display("FAIL ignore_st_result: cosh=%0d sinh=%0d, required 18475 8538 (+-8)",
                     c, s);
        end
        $display("ignore_st: lat=%0d pulses=%0d cosh=%0d sinh=%0d", lat, pulses, c, s);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int spurious;
        int c;
        int s;
        spurious = 0;
        @(negedge clk);
        bus.z_in = 16'h4000;
        bus.st   = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.cosh_out !== 16'h0000 || bus.sinh_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b cosh=%h sinh=%h, required 0 0 0000 0000",
                     bus.busy, bus.done, bus.cosh_out, bus.sinh_out);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midrun_no_done: done seen %0d times, required 0", spurious);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h2000, lat, c, s);
        checks++;
        if (lat != 18 || absdiff(c, 18475) > TOL || absdiff(s, 8538) > TOL) begin
            errors++;
            $display("FAIL midrun_recover: lat=%0d cosh=%0d sinh=%0d, required 18 18475 8538 (+-8)",
                     lat, c, s);
        end
        $display("reset_mid_run: recover lat=%0d cosh=%0d sinh=%0d", lat, c, s);
    endtask

    // st held high: restarts in the first IDLE cycle, done every 19 cycles.
    task automatic test_back_to_back();
        int first;
        int second;
        int pulses;
        int busy_at_first;
        int c;
        int s;
        first         = -1;
        second        = -1;
        pulses        = 0;
        busy_at_first = -1;
        @(negedge clk);
        bus.z_in = 16'h4000;
        bus.st   = 1'b1;
        @(posedge clk);
        #1;
        bus.z_in = 16'hE000;
        for (int n = 1; n <= 2 * TIMEOUT; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first         = n;
                    busy_at_first = int'(bus.busy);
                    c = int'($signed(bus.cosh_out));
                    s = int'($signed(bus.sinh_out));
                    checks++;
                    if (absdiff(c, 25281) > TOL || absdiff(s, 19254) > TOL) begin
                        errors++;
                        $display("FAIL b2b_first_result: cosh=%0d sinh=%0d, required 25281 19254 (+-8)",
                                 c, s);
                    end
                end else begin
                    second = n;
                    bus.st = 1'b0;
                    break;
                end
            end
        end
        bus.st = 1'b0;
        c = int'($signed(bus.cosh_out));
        s = int'($signed(bus.sinh_out));
        checks++;
        if (first != 18 || second != 37 || pulses != 2) begin
            errors++;
            $display("FAIL b2b_timing: done at %0d and %0d (%0d pulses), required 18 and 37",
                     first, second, pulses);
        end
        checks++;
        if (busy_at_first != 0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%0d at E18, required 0", busy_at_first);
        end
        checks++;
        if (absdiff(c, 18475) > TOL || absdiff(s, -8538) > TOL) begin
            errors++;
            $display("FAIL b2b_second_result: cosh=%0d sinh=%0d, required 18475 -8538 (+-8)",
                     c, s);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b after st dropped, required 0", bus.busy);
        end
        $display("back_to_back: done at %0d,%0d cosh=%0d sinh=%0d", first, second, c, s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_angles();
        test_ignore_st();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sinh_cosh_h.md
SINH_COSH_H -- requirements
Module: sinh_cosh_h

Interface
REQ-001 Parameter: N, default 16, data word width in bits; the block is specified and verified only at N=16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 st  input  1  start request, sampled on rising clk in IDLE only.
REQ-005 z_in  input  16  signed Q2.14 hyperbolic angle, sampled on the start edge.
REQ-006 cosh_out  output  16  signed Q2.14 cosh(z), registered, held until next completion.
REQ-007 sinh_out  output  16  signed Q2.14 sinh(z), registered, held until next completion.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  registered one-cycle completion pulse.

Function
REQ-010 Block SHALL implement hyperbolic CORDIC in rotation mode: drive residual z to 0, accumulating x->cosh, y->sinh.
REQ-011 State machine SHALL have states IDLE, RUN, DONE; IDLE->RUN on st=1; RUN->DONE after final micro-rotation; DONE->IDLE unconditionally after one cycle.
REQ-012 On start edge: x <= 0x4D48 (1/K_h = 1.20750), y <= 0, z <= z_in saturated to [-16384, +16384], step counter <= 0.
REQ-013 RUN SHALL perform exactly 17 micro-rotations, one per clock, using shift index sequence 1,2,3,4,4,5,...,13,13,14,15 (indices 4 and 13 repeated).
REQ-014 Per micro-rotation with shift i: d=+1 if z>=0 else -1; x' = x + d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATANH[i]; all updates from pre-edge values.
REQ-015 Shifts SHALL be arithmetic; adds/subtracts 16-bit two's complement, no internal saturation.
REQ-016 ATANH ROM (Q2.14), i=1..15: 0x2327, 0x1058, 0x080A, 0x0401, 0x0200, 0x0100, 0x0080, 0x0040, 0x0020, 0x0010, 0x0008, 0x0004, 0x0002, 0x0001, 0x0000.
REQ-017 Latency: start edge E0; rotations at E1..E17; state DONE during cycle E17..E18; at E18 cosh_out<=x, sinh_out<=y, done<=1, state<=IDLE; done deasserts at E19.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 st SHALL be ignored while busy=1; no queuing of requests.
REQ-020 st held high continuously SHALL re-start at E19 (first IDLE cycle), giving back-to-back 19-cycle operations.
REQ-021 z_in change after start edge SHALL NOT affect the running computation.
REQ-022 Accuracy: for |z_in|<=16384, results within ±8 LSB of exact cosh/sinh scaled by 2^14.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, cosh_out=0, sinh_out=0, x=y=z=0, step counter=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no output update for that operation.
REQ-025 First start SHALL be accepted on the first rising clk with rst_n=1 and st=1.

Verification
REQ-026 z_in=0x0000, st pulse -> done at E18+; cosh_out=16384±8, sinh_out=0±8; busy high E0..E18.
REQ-027 z_in=0x2000 (0.5) -> cosh_out=18475±8, sinh_out=8538±8; z_in=0xE000 (-0.5) -> cosh_out=18475±8, sinh_out=-8538±8.
REQ-028 z_in=0x4000 (1.0) -> cosh_out=25281±8, sinh_out=19254±8; z_in=0x6000 (1.5, saturated) -> same as 1.0.
REQ-029 Start 0x2000, pulse st and change z_in at E5 -> st ignored, result unchanged, single done pulse at E18.
REQ-030 Start 0x4000, drop rst_n at E9 -> outputs 0, busy=0 immediately, no done; release, start 0x2000 -> correct result 19 cycles later.
